// File: rtl/fifo_v4.sv
// fifo_v4 -- parametrised synchronous FIFO, valid/ready on both sides.
//
// Optional feature macro: FIFO_V4_WATERMARK_EN
//   defined   : max_usage_o reports the highest usage seen since rst_i
//   undefined : max_usage_o is tied to '0, no register is built
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   flush_i        synchronous flush (empties FIFO, keeps watermark)
//   in_data_i      write data
//   in_valid_i     write request
//   in_ready_o     FIFO can accept (not full)
//   out_data_o     head element (in_data_i when FALL_THROUGH and empty)
//   out_valid_o    head valid
//   out_ready_i    consumer accepts
//   usage_o        entries stored, 0..DEPTH
//   full_o         usage == DEPTH
//   empty_o        usage == 0
//   almost_full_o  usage >= ALMOST_FULL_TH
//   almost_empty_o usage <= ALMOST_EMPTY_TH
//   max_usage_o    high-watermark of usage
module fifo_v4 #(
  parameter logic        FALL_THROUGH    = 1'b0,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEPTH           = 8,
  parameter type         dtype           = logic [DATA_WIDTH-1:0],
  parameter int unsigned ALMOST_FULL_TH  = DEPTH - 1,
  parameter int unsigned ALMOST_EMPTY_TH = 1,
  parameter int unsigned CNT_W           = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  dtype             in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output dtype             out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] usage_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CNT_W-1:0] max_usage_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(ALMOST_FULL_TH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(ALMOST_EMPTY_TH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  if (DEPTH == 0) begin : g_bad_depth
    $fatal(1, "fifo_v4: DEPTH must be >= 1");
  end

`ifndef SYNTHESIS
  if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : g_bad_af
    $error("fifo_v4: ALMOST_FULL_TH outside 1..DEPTH");
  end
  if (ALMOST_EMPTY_TH >= DEPTH) begin : g_bad_ae
    $error("fifo_v4: ALMOST_EMPTY_TH outside 0..DEPTH-1");
  end
`endif

  dtype             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             wr_adv;
  logic             rd_adv;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Flags decode only the registered count, so in_ready_o never depends
  // combinationally on out_ready_i.
  always_comb begin
    full_o         = (count_q == DEPTH_C);
    empty_o        = (count_q == '0);
    almost_full_o  = (count_q >= AF_C);
    almost_empty_o = (count_q <= AE_C);
    usage_o        = count_q;
    in_ready_o     = ~full_o;
  end

  always_comb begin
    out_valid_o = ~empty_o | (FALL_THROUGH & in_valid_i);
    out_data_o  = mem[rd_ptr_q];
    if (FALL_THROUGH && empty_o) begin
      out_data_o = in_data_i;
    end
  end

  // When empty in fall-through mode, a pop implies a push of the same
  // element: it passes straight through and the storage is left untouched.
  always_comb begin
    push    = in_valid_i & in_ready_o;
    pop     = out_valid_o & out_ready_i;
    bypass  = FALL_THROUGH & empty_o & push & pop;
    wr_adv  = push & ~bypass;
    rd_adv  = pop & ~bypass;
    count_d = count_q;
    if (wr_adv && !rd_adv) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_adv && !wr_adv) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_adv) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (rd_adv) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  // Storage has no reset; write enable is the only qualifier.
  always_ff @(posedge clk_i) begin
    if (wr_adv && !flush_i && !rst_i) begin
      mem[wr_ptr_q] <= in_data_i;
    end
  end

`ifdef FIFO_V4_WATERMARK_EN
  logic [CNT_W-1:0] max_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      max_q <= '0;
    end else if (!flush_i && count_d > max_q) begin
      max_q <= count_d;
    end
  end

  assign max_usage_o = max_q;
`else
  assign max_usage_o = '0;
`endif

`ifndef SYNTHESIS
  logic [PTR_W:0] ptr_diff;

  always_comb begin
    if (wr_ptr_q >= rd_ptr_q) begin
      ptr_diff = {1'b0, wr_ptr_q} - {1'b0, rd_ptr_q};
    end else begin
      ptr_diff = {1'b0, wr_ptr_q} + (PTR_W + 1)'(DEPTH) - {1'b0, rd_ptr_q};
    end
  end

  a_usage_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= DEPTH_C);

  // Equal pointers mean either empty or full; the count decides which.
  a_count_ptrs : assert property (@(posedge clk_i) disable iff (rst_i)
    (CNT_W'(ptr_diff) == count_q) || (ptr_diff == '0 && count_q == DEPTH_C));
`endif

endmodule
